// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and helpers for the program-counter sequencer:
//               Y86 instruction codes, status/state encodings, the
//               instruction-length table and the icode validity check.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    typedef enum logic [3:0] {
        ICODE_HALT  = 4'h0,
        ICODE_NOP   = 4'h1,
        ICODE_RRMOV = 4'h2,
        ICODE_IRMOV = 4'h3,
        ICODE_RMMOV = 4'h4,
        ICODE_MRMOV = 4'h5,
        ICODE_OP    = 4'h6,
        ICODE_JXX   = 4'h7,
        ICODE_CALL  = 4'h8,
        ICODE_RET   = 4'h9,
        ICODE_PUSH  = 4'hA,
        ICODE_POP   = 4'hB
    } icode_e;

    typedef enum logic [1:0] {
        STAT_AOK = 2'b00,
        STAT_HLT = 2'b01,
        STAT_INS = 2'b10,
        STAT_STK = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_ERROR  = 2'd2
    } state_e;

    // Encoded length in bytes; invalid codes return 0 (never used for PC).
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        logic [3:0] len;
        case (icode)
            4'h0, 4'h1, 4'h9:             len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:       len = 4'd2;
            4'h3, 4'h4, 4'h5:             len = 4'd10;
            4'h7, 4'h8:                   len = 4'd9;
            default:                      len = 4'd0;
        endcase
        return len;
    endfunction

    function automatic logic icode_is_valid(input logic [3:0] icode);
        return (icode <= 4'hB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
// Module      : ras_stack
// Description : Return-address LIFO. push writes din on top, pop discards the
//               top entry; dout always shows the current top.
//               Ports: clock, reset (sync, active-high), push, pop, din,
//               dout (top entry), depth (occupancy), full, empty.
//               The parent never issues push and pop in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]   mem_q [DEPTH];
    logic [PTR_W:0] count_q;
    logic [PTR_W:0] count_d;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign depth   = count_q;
    assign wr_idx  = count_q[PTR_W-1:0];
    // When full the low bits wrap to 0, so subtracting one still lands on DEPTH-1.
    assign top_idx = count_q[PTR_W-1:0] - PTR_W'(1);
    assign dout    = mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (push && !full) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries above the occupancy count are never read.
    always_ff @(posedge clock) begin
        if (!reset && push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Y86 program counter. Advances by the decoded instruction
//               length on each accepted instruction, redirects on jXX/call/
//               ret via an internal return-address stack, and reports
//               halt/error status and a retired-instruction count.
//               Ports: clock, reset, icode_input, instr_valid, stall,
//               branch_taken, dest_addr -> pc_out, pc_valid, status,
//               ras_depth, retired_count.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter int          RAS_DEPTH = 8,
    parameter int          COUNT_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [3:0]                   icode_input,
    input  logic                         instr_valid,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [ADDR_W-1:0]            dest_addr,
    output logic [ADDR_W-1:0]            pc_out,
    output logic                         pc_valid,
    output logic [1:0]                   status,
    output logic [$clog2(RAS_DEPTH):0]   ras_depth,
    output logic [COUNT_W-1:0]           retired_count
);

    state_e              state_q,   state_d;
    status_e             status_q,  status_d;
    logic [ADDR_W-1:0]   pc_q,      pc_d;
    logic [COUNT_W-1:0]  retired_q, retired_d;

    logic                accept;
    logic [ADDR_W-1:0]   val_p;
    logic                ras_push;
    logic                ras_pop;
    logic [ADDR_W-1:0]   ras_top;
    logic                ras_full;
    logic                ras_empty;

    assign accept = (state_q == ST_RUN) && instr_valid && !stall;
    assign val_p  = pc_q + ADDR_W'(instr_len(icode_input));

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        if (accept) begin
            if (!icode_is_valid(icode_input)) begin
                state_d  = ST_ERROR;
                status_d = STAT_INS;
            end else begin
                // Every valid code retires unless it faults on the stack below.
                retired_d = retired_q + COUNT_W'(1);
                case (icode_input)
                    ICODE_HALT: begin
                        state_d  = ST_HALTED;
                        status_d = STAT_HLT;
                    end
                    ICODE_JXX: begin
                        pc_d = branch_taken ? dest_addr : val_p;
                    end
                    ICODE_CALL: begin
                        if (ras_full) begin
                            state_d   = ST_ERROR;
                            status_d  = STAT_STK;
                            retired_d = retired_q;
                        end else begin
                            pc_d     = dest_addr;
                            ras_push = 1'b1;
                        end
                    end
                    ICODE_RET: begin
                        if (ras_empty) begin
                            state_d   = ST_ERROR;
                            status_d  = STAT_STK;
                            retired_d = retired_q;
                        end else begin
                            pc_d    = ras_top;
                            ras_pop = 1'b1;
                        end
                    end
                    default: begin
                        pc_d = val_p;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RUN;
            status_q  <= STAT_AOK;
            pc_q      <= RESET_PC;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clock (clock),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (val_p),
        .dout  (ras_top),
        .depth (ras_depth),
        .full  (ras_full),
        .empty (ras_empty)
    );

    assign pc_out        = pc_q;
    assign status        = status_q;
    assign retired_count = retired_q;
    assign pc_valid      = (state_q == ST_RUN) && !stall && !reset;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer. A default
//               16-bit instance carries most scenarios; an 8-bit instance
//               with RESET_PC=0xFA covers address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  icode_input = 4'h1;
    logic        instr_valid = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] dest_addr = '0;

    logic [15:0] pc_out;
    logic        pc_valid;
    logic [1:0]  status;
    logic [3:0]  ras_depth;
    logic [31:0] retired_count;

    logic [7:0]  pc_out8;
    logic        pc_valid8;
    logic [1:0]  status8;
    logic [1:0]  ras_depth8;
    logic [3:0]  retired8;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .icode_input   (icode_input),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .dest_addr     (dest_addr),
        .pc_out        (pc_out),
        .pc_valid      (pc_valid),
        .status        (status),
        .ras_depth     (ras_depth),
        .retired_count (retired_count)
    );

    pc_sequencer #(
        .ADDR_W    (8),
        .RAS_DEPTH (2),
        .COUNT_W   (4),
        .RESET_PC  (8'hFA)
    ) dut8 (
        .clock         (clock),
        .reset         (reset),
        .icode_input   (icode_input),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .dest_addr     (dest_addr[7:0]),
        .pc_out        (pc_out8),
        .pc_valid      (pc_valid8),
        .status        (status8),
        .ras_depth     (ras_depth8),
        .retired_count (retired8)
    );

    // Inputs change 1 ns after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; instr_valid = 1'b0; stall = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic issue(input logic [3:0] ic, input logic tk, input logic [15:0] dst);
        icode_input = ic; branch_taken = tk; dest_addr = dst;
        instr_valid = 1'b1; stall = 1'b0;
        tick();
        instr_valid = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pc_valid got %0b want 0", pc_valid); end
        n_cmp++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL rst_pc got %h want 0000", pc_out); end
        n_cmp++; if (status !== 2'b00) begin n_fail++; $display("FAIL rst_status got %b want 00", status); end
        n_cmp++; if (ras_depth !== 4'd0) begin n_fail++; $display("FAIL rst_ras got %0d want 0", ras_depth); end
        n_cmp++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL rst_retired got %0d want 0", retired_count); end
        n_cmp++; if (pc_out8 !== 8'hFA) begin n_fail++; $display("FAIL rst_pc8 got %h want fa", pc_out8); end
        reset = 1'b0;
        #1;
        n_cmp++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL run_pc_valid got %0b want 1", pc_valid); end
    endtask

    task automatic test_sequential();
        do_reset();
        issue(4'h1, 1'b0, 16'h0);
        n_cmp++; if (pc_out !== 16'h0001) begin n_fail++; $display("FAIL seq_nop got %h want 0001", pc_out); end
        issue(4'h3, 1'b0, 16'h0);
        n_cmp++; if (pc_out !== 16'h000B) begin n_fail++; $display("FAIL seq_irmov got %h want 000b", pc_out); end
        issue(4'h2, 1'b0, 16'h0);
        n_cmp++; if (pc_out !== 16'h000D) begin n_fail++; $display("FAIL seq_rrmov got %h want 000d", pc_out); end
        n_cmp++; if (retired_count !== 32'd3) begin n_fail++; $display("FAIL seq_retired got %0d want 3", retired_count); end
    endtask

    task automatic test_jump();
        do_reset();
        issue(4'h7, 1'b1, 16'h0020);
        n_cmp++; if (pc_out !== 16'h0020) begin n_fail++; $display("FAIL jmp_setup got %h want 0020", pc_out); end
        issue(4'h7, 1'b1, 16'h0100);
        n_cmp++; if (pc_out !== 16'h0100) begin n_fail++; $display("FAIL jmp_taken got %h want 0100", pc_out); end
        do_reset();
        issue(4'h7, 1'b1, 16'h0020);
        issue(4'h7, 1'b0, 16'h0100);
        n_cmp++; if (pc_out !== 16'h0029) begin n_fail++; $display("FAIL jmp_not_taken got %h want 0029", pc_out); end
        n_cmp++; if (retired_count !== 32'd2) begin n_fail++; $display("FAIL jmp_retired got %0d want 2", retired_count); end
    endtask

    task automatic test_call_ret();
        do_reset();
        issue(4'h7, 1'b1, 16'h0010);
        issue(4'h8, 1'b0, 16'h0200);
        n_cmp++; if (pc_out !== 16'h0200) begin n_fail++; $display("FAIL call_pc got %h want 0200", pc_out); end
        n_cmp++; if (ras_depth !== 4'd1) begin n_fail++; $display("FAIL call_ras got %0d want 1", ras_depth); end
        issue(4'h9, 1'b0, 16'h0);
        n_cmp++; if (pc_out !== 16'h0019) begin n_fail++; $display("FAIL ret_pc got %h want 0019", pc_out); end
        n_cmp++; if (ras_depth !== 4'd0) begin n_fail++; $display("FAIL ret_ras got %0d want 0", ras_depth); end
        n_cmp++; if (status !== 2'b00) begin n_fail++; $display("FAIL ret_status got %b want 00", status); end
    endtask

    task automatic test_ret_empty();
        do_reset();
        issue(4'h1, 1'b0, 16'h0);
        issue(4'h9, 1'b0, 16'h0);
        n_cmp++; if (status !== 2'b11) begin n_fail++; $display("FAIL ret_empty_status got %b want 11", status); end
        n_cmp++; if (pc_out !== 16'h0001) begin n_fail++; $display("FAIL ret_empty_pc got %h want 0001", pc_out); end
        n_cmp++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL ret_empty_valid got %0b want 0", pc_valid); end
        issue(4'h1, 1'b0, 16'h0);
        n_cmp++; if (pc_out !== 16'h0001) begin n_fail++; $display("FAIL err_ignore_pc got %h want 0001", pc_out); end
        n_cmp++; if (retired_count !== 32'd1) begin n_fail++; $display("FAIL err_ignore_retired got %0d want 1", retired_count); end
    endtask

    task automatic test_call_overflow();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            issue(4'h8, 1'b0, 16'(i * 16'h0040));
        end
        n_cmp++; if (ras_depth !== 4'd8) begin n_fail++; $display("FAIL ovf_ras_full got %0d want 8", ras_depth); end
        n_cmp++; if (pc_out !== 16'h0200) begin n_fail++; $display("FAIL ovf_pc8 got %h want 0200", pc_out); end
        issue(4'h8, 1'b0, 16'h0900);
        n_cmp++; if (status !== 2'b11) begin n_fail++; $display("FAIL ovf_status got %b want 11", status); end
        n_cmp++; if (pc_out !== 16'h0200) begin n_fail++; $display("FAIL ovf_pc_hold got %h want 0200", pc_out); end
        n_cmp++; if (ras_depth !== 4'd8) begin n_fail++; $display("FAIL ovf_ras_hold got %0d want 8", ras_depth); end
        n_cmp++; if (retired_count !== 32'd8) begin n_fail++; $display("FAIL ovf_retired got %0d want 8", retired_count); end
    endtask

    task automatic test_invalid();
        do_reset();
        issue(4'hE, 1'b0, 16'h0);
        n_cmp++; if (status !== 2'b10) begin n_fail++; $display("FAIL ins_status got %b want 10", status); end
        n_cmp++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL ins_pc got %h want 0000", pc_out); end
        n_cmp++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL ins_retired got %0d want 0", retired_count); end
    endtask

    task automatic test_halt();
        do_reset();
        issue(4'h1, 1'b0, 16'h0);
        issue(4'h0, 1'b0, 16'h0);
        n_cmp++; if (status !== 2'b01) begin n_fail++; $display("FAIL hlt_status got %b want 01", status); end
        n_cmp++; if (pc_out !== 16'h0001) begin n_fail++; $display("FAIL hlt_pc got %h want 0001", pc_out); end
        n_cmp++; if (retired_count !== 32'd2) begin n_fail++; $display("FAIL hlt_retired got %0d want 2", retired_count); end
        n_cmp++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL hlt_valid got %0b want 0", pc_valid); end
        issue(4'h3, 1'b0, 16'h0);
        n_cmp++; if (pc_out !== 16'h0001) begin n_fail++; $display("FAIL hlt_ignore_pc got %h want 0001", pc_out); end
        do_reset();
        n_cmp++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL hlt_reset_pc got %h want 0000", pc_out); end
        n_cmp++; if (status !== 2'b00) begin n_fail++; $display("FAIL hlt_reset_status got %b want 00", status); end
    endtask

    task automatic test_stall();
        do_reset();
        icode_input = 4'h3; instr_valid = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid c%0d got %0b want 0", i, pc_valid); end
        end
        n_cmp++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL stall_pc got %h want 0000", pc_out); end
        n_cmp++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL stall_retired got %0d want 0", retired_count); end
        stall = 1'b0;
        tick();
        instr_valid = 1'b0;
        n_cmp++; if (pc_out !== 16'h000A) begin n_fail++; $display("FAIL unstall_pc got %h want 000a", pc_out); end
        // Reset while stalled must still restore the reset state.
        issue(4'h8, 1'b0, 16'h0300);
        stall = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; stall = 1'b0;
        n_cmp++; if (pc_out !== 16'h0000) begin n_fail++; $display("FAIL stall_rst_pc got %h want 0000", pc_out); end
        n_cmp++; if (ras_depth !== 4'd0) begin n_fail++; $display("FAIL stall_rst_ras got %0d want 0", ras_depth); end
    endtask

    task automatic test_wrap();
        do_reset();
        n_cmp++; if (pc_out8 !== 8'hFA) begin n_fail++; $display("FAIL wrap_start got %h want fa", pc_out8); end
        issue(4'h3, 1'b0, 16'h0);
        n_cmp++; if (pc_out8 !== 8'h04) begin n_fail++; $display("FAIL wrap_pc got %h want 04", pc_out8); end
        n_cmp++; if (status8 !== 2'b00) begin n_fail++; $display("FAIL wrap_status got %b want 00", status8); end
        n_cmp++; if (retired8 !== 4'd1) begin n_fail++; $display("FAIL wrap_retired got %0d want 1", retired8); end
        n_cmp++; if (pc_valid8 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %0b want 1", pc_valid8); end
        n_cmp++; if (ras_depth8 !== 2'd0) begin n_fail++; $display("FAIL wrap_ras got %0d want 0", ras_depth8); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_call_ret();
        test_ret_empty();
        test_call_overflow();
        test_invalid();
        test_halt();
        test_stall();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
